// File: rtl/fp32_mul_service.sv
// Multi-cycle IEEE-754 binary32 multiplier (IDLE/UNPACK/MULT/NORM/ROUND), RNE, flush-to-zero.
// Optional sticky exception output enabled by defining CALC_EXCEPTION_EN.
module fp32_mul_service #(
   parameter int DATA_SIZE = 32
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   input  logic                 start,
   output logic [DATA_SIZE-1:0] result,
   output logic                 busy,
`ifdef CALC_EXCEPTION_EN
   output logic                 exception,
`endif
   output logic [2:0]           dbg_state_o
);

   if (DATA_SIZE != 32) begin : g_size_check
      $error("fp32_mul_service supports DATA_SIZE == 32 only");
   end

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND} state_t;

   // Handshake: start is accepted on a rising edge only while busy is low; busy
   // then stays high for four cycles and result is valid once busy has fallen.
   state_t             state_q, state_d;
   logic [31:0]        a_q, b_q;
   logic               sign_q;
   logic [7:0]         ea_q, eb_q;
   logic [23:0]        ma_q, mb_q;
   logic               nan_q, inv_q, inf_q, zero_q;
   logic [47:0]        prod_q;
   logic signed [9:0]  exp_q;
   logic [22:0]        frac_q;
   logic               guard_q, sticky_q;
   logic [31:0]        result_q, res_d;
   logic               busy_q;

   logic               a_zd, b_zd, a_inf, b_inf, a_nan, b_nan;
   logic               round_up;
   logic [23:0]        frac_rnd;
   logic signed [9:0]  exp_fin;

   assign a_zd  = (a_q[30:23] == 8'd0);
   assign b_zd  = (b_q[30:23] == 8'd0);
   assign a_inf = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
   assign b_inf = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
   assign a_nan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
   assign b_nan = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_UNPACK;
         S_UNPACK: state_d = S_MULT;
         S_MULT:   state_d = S_NORM;
         S_NORM:   state_d = S_ROUND;
         S_ROUND:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Carry out of the rounded fraction means 1.111.. rounded up to 10.000..; the
   // remaining fraction bits are already zero, so only the exponent moves.
   always_comb begin
      round_up = guard_q & (sticky_q | frac_q[0]);
      frac_rnd = {1'b0, frac_q} + {23'd0, round_up};
      exp_fin  = exp_q + (frac_rnd[23] ? 10'sd1 : 10'sd0);
      if (nan_q || inv_q)        res_d = 32'h7FC00000;
      else if (inf_q)            res_d = {sign_q, 8'hFF, 23'd0};
      else if (zero_q)           res_d = {sign_q, 31'd0};
      else if (exp_fin >= 10'sd255) res_d = {sign_q, 8'hFF, 23'd0};
      else if (exp_fin <= 10'sd0)   res_d = {sign_q, 31'd0};
      else                       res_d = {sign_q, exp_fin[7:0], frac_rnd[22:0]};
   end

`ifdef CALC_EXCEPTION_EN
   logic exc_q, exc_d;
   always_comb begin
      exc_d = 1'b0;
      if (nan_q)                                exc_d = 1'b0;
      else if (inv_q)                           exc_d = 1'b1;
      else if (inf_q || zero_q)                 exc_d = 1'b0;
      else if ((exp_fin >= 10'sd255) || (exp_fin <= 10'sd0)) exc_d = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)                exc_q <= 1'b0;
      else if (state_q == S_ROUND) exc_q <= exc_d;
   end

   assign exception = exc_q;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         result_q <= 32'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         sign_q   <= 1'b0;
         ea_q     <= 8'd0;
         eb_q     <= 8'd0;
         ma_q     <= 24'd0;
         mb_q     <= 24'd0;
         nan_q    <= 1'b0;
         inv_q    <= 1'b0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
         prod_q   <= 48'd0;
         exp_q    <= 10'sd0;
         frac_q   <= 23'd0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            S_UNPACK: begin
               sign_q <= a_q[31] ^ b_q[31];
               ea_q   <= a_q[30:23];
               eb_q   <= b_q[30:23];
               ma_q   <= {1'b1, a_q[22:0]};
               mb_q   <= {1'b1, b_q[22:0]};
               nan_q  <= a_nan | b_nan;
               inv_q  <= (a_inf & b_zd) | (b_inf & a_zd);
               inf_q  <= a_inf | b_inf;
               zero_q <= a_zd | b_zd;
            end
            S_MULT: begin
               prod_q <= {24'd0, ma_q} * {24'd0, mb_q};
               exp_q  <= $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
            end
            S_NORM: begin
               if (prod_q[47]) begin
                  frac_q   <= prod_q[46:24];
                  guard_q  <= prod_q[23];
                  sticky_q <= |prod_q[22:0];
                  exp_q    <= exp_q + 10'sd1;
               end else begin
                  frac_q   <= prod_q[45:23];
                  guard_q  <= prod_q[22];
                  sticky_q <= |prod_q[21:0];
               end
            end
            S_ROUND: result_q <= res_d;
            default: ;
         endcase
      end
   end

   assign result      = result_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp32_mul_service.sv
// Self-checking bench for fp32_mul_service: directed cases, held-start pacing,
// mid-operation reset and random operands against a real-arithmetic reference.
module tb_fp32_mul_service;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] result;
   logic        busy;
   logic [2:0]  dbg_state;
`ifdef CALC_EXCEPTION_EN
   logic        exception;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 aclk = ~aclk;

   fp32_mul_service #(.DATA_SIZE(32)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .a           (a),
      .b           (b),
      .start       (start),
      .result      (result),
      .busy        (busy),
`ifdef CALC_EXCEPTION_EN
      .exception   (exception),
`endif
      .dbg_state_o (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference: exact product as a real, normalised by halving, rounded ties-to-even.
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y, output logic exc);
      logic   s, xn, yn, xi, yi, xz, yz;
      longint p, q;
      real    m, fl;
      int     e2;
      s  = x[31] ^ y[31];
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      xz = (x[30:23] == 8'h00);
      yz = (y[30:23] == 8'h00);
      exc = 1'b0;
      if (xn || yn) return 32'h7FC00000;
      if ((xi && yz) || (yi && xz)) begin exc = 1'b1; return 32'h7FC00000; end
      if (xi || yi) return {s, 8'hFF, 23'd0};
      if (xz || yz) return {s, 31'd0};
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      m  = real'(p);
      e2 = int'(x[30:23]) + int'(y[30:23]) - 300;
      while (m >= 16777216.0) begin
         m  = m / 2.0;
         e2 = e2 + 1;
      end
      fl = $floor(m);
      if ((m - fl > 0.5) || ((m - fl == 0.5) && (longint'(fl) % 2 == 1))) fl = fl + 1.0;
      if (fl >= 16777216.0) begin
         fl = fl / 2.0;
         e2 = e2 + 1;
      end
      e2 = e2 + 150;
      if (e2 >= 255) begin exc = 1'b1; return {s, 8'hFF, 23'd0}; end
      if (e2 <= 0)   begin exc = 1'b1; return {s, 31'd0}; end
      q = longint'(fl);
      return {s, e2[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      if ($urandom_range(0, 3) == 0) r = $urandom;
      else begin
         r = $urandom;
         r[30:23] = 8'($urandom_range(64, 190));
      end
      return r;
   endfunction

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] er;
      logic        ee;
      int          n;
      er = ref_mul(x, y, ee);
      @(negedge aclk);
      a = x; b = y; start = 1'b1;
      @(posedge aclk);
      #1 start = 1'b0;
      check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 20) begin
         @(posedge aclk);
         #1 n++;
      end
      check({tag, "_latency"}, n, 32'd4);
      check(tag, result, er);
`ifdef CALC_EXCEPTION_EN
      check({tag, "_exc"}, {31'd0, exception}, {31'd0, ee});
`endif
   endtask

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra[15];
      logic [31:0] rb[15];
      logic [31:0] er, last;
      logic        ee;

      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_result", result, 32'd0);
`ifdef CALC_EXCEPTION_EN
      check("reset_exc", {31'd0, exception}, 32'd0);
`endif
      @(posedge aclk);
      #2 aresetn = 1'b1;

      run_op(32'h3FC00000, 32'h40000000, "mul_1p5x2");
      check("mul_1p5x2_const", result, 32'h40400000);
      run_op(32'hC0000000, 32'h40400000, "mul_m2x3");
      check("mul_m2x3_const", result, 32'hC0C00000);
      run_op(32'h3F800001, 32'h3F800001, "rne_sticky");
      check("rne_sticky_const", result, 32'h3F800002);
      run_op(32'h3F800000, 32'h00400000, "denorm_ftz");
      run_op(32'h7F800000, 32'h00000000, "inf_x_zero");
      run_op(32'h7FC00001, 32'h3F800000, "nan_in");
      run_op(32'h7F7FFFFF, 32'h40000000, "overflow");
      run_op(32'h00800000, 32'h00800000, "underflow");
      run_op(32'hFF800000, 32'h40000000, "neg_inf_x2");
      run_op(32'h80000000, 32'h3F800000, "negzero");

      // start held high, operands change every cycle: accepts at k = 0, 5, 10
      for (int k = 0; k < 15; k++) begin
         ra[k] = rand_op();
         rb[k] = rand_op();
      end
      for (int k = 0; k < 15; k++) begin
         @(negedge aclk);
         a = ra[k]; b = rb[k]; start = 1'b1;
         @(posedge aclk);
         #1;
         check($sformatf("held_busy_%0d", k), {31'd0, busy}, (k % 5 != 4) ? 32'd1 : 32'd0);
         if (k % 5 == 4) begin
            er = ref_mul(ra[k-4], rb[k-4], ee);
            check($sformatf("held_result_%0d", k), result, er);
         end
      end
      @(negedge aclk);
      start = 1'b0;
      last = ref_mul(ra[10], rb[10], ee);
      repeat (3) @(posedge aclk);
      #1;
      check("held_result_hold", result, last);
      check("held_idle", {31'd0, busy}, 32'd0);

      // reset two cycles into an operation
      @(negedge aclk);
      a = 32'h40400000; b = 32'h40400000; start = 1'b1;
      @(posedge aclk);
      #1 start = 1'b0;
      @(posedge aclk);
      @(posedge aclk);
      #2 aresetn = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_result", result, 32'd0);
      repeat (6) @(posedge aclk);
      #1;
      check("rst_no_completion", result, 32'd0);
      #1 aresetn = 1'b1;
      run_op(32'h40400000, 32'h40400000, "after_reset");
      check("after_reset_const", result, 32'h41100000);

      for (int i = 0; i < 40; i++) begin
         run_op(rand_op(), rand_op(), $sformatf("rand_%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
